permutation_ctrl: RTL and testbench

- Round scheduler for the ASCON-AEAD128 permutation datapath: constant addition, then substitution, then linear diffusion, one round per clock.
- Accepts a start request for p^a (12 rounds) or p^b (8 rounds).
- Steps a round counter and drives round index, round constant, state-register mux select and state-register enable.
- Reports completion to the AEAD mode FSM.
- Holds no 320-bit state itself; the state register and round logic live in the permutation datapath.

---
 rtl/permutation_ctrl.sv | 112 +++++++++++
 tb/tb_permutation_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/permutation_ctrl.sv
// Round scheduler for the ASCON-AEAD128 permutation datapath: sequences p^a / p^b
// rounds, driving round index, round constant and state-register controls.
module permutation_ctrl #(
  parameter int unsigned NB_ROUNDS_A = 12,
  parameter int unsigned NB_ROUNDS_B = 8
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       abort_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic [3:0] round_o,
  output logic [7:0] const_o,
  output logic       sel_init_o,
  output logic       en_reg_state_o,
  output logic       done_o,
  output logic [1:0] dbg_state_o
);

  // Handshake: a request is taken on a rising edge where ready_o=1, start_i=1 and
  // abort_i=0; the matching done_o is a single-cycle pulse, never back-pressured.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LP_FIRST_A = 4'(12 - NB_ROUNDS_A);
  localparam logic [3:0] LP_FIRST_B = 4'(12 - NB_ROUNDS_B);
  localparam logic [3:0] LP_LAST    = 4'd11;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_round;
  logic       r_first;
  logic       w_accept;
  logic [3:0] w_const_hi;

  assign w_accept = (r_state == S_IDLE) && start_i && !abort_i;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_ROUND;
      end
      S_ROUND: begin
        if (abort_i)                 w_next_state = S_IDLE;
        else if (r_round == LP_LAST) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o        = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    sel_init_o     = 1'b0;
    en_reg_state_o = 1'b0;
    case (r_state)
      S_IDLE: ready_o = 1'b1;
      S_ROUND: begin
        busy_o         = 1'b1;
        en_reg_state_o = 1'b1;
        sel_init_o     = r_first;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Counter starts at 12-N so the last round is always 11; it saturates there.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_round <= 4'd0;
      r_first <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_round <= mode_i ? LP_FIRST_B : LP_FIRST_A;
            r_first <= 1'b1;
          end
        end
        S_ROUND: begin
          r_first <= 1'b0;
          if (r_round != LP_LAST) r_round <= r_round + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_const_hi  = 4'hF - r_round;
  assign round_o     = r_round;
  assign const_o     = {w_const_hi, r_round};
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_permutation_ctrl.sv
// Scoreboard bench for permutation_ctrl: expected enable/done events are queued at
// stimulus time and a negedge monitor pops and compares them as the DUT emits them.
module tb_permutation_ctrl;

  logic       clock_i;
  logic       resetb_i;
  logic       start_i;
  logic       mode_i;
  logic       abort_i;
  logic       ready_o;
  logic       busy_o;
  logic [3:0] round_o;
  logic [7:0] const_o;
  logic       sel_init_o;
  logic       en_reg_state_o;
  logic       done_o;
  logic [1:0] dbg_state_o;

  int vec_count = 0;
  int err_count = 0;

  // Event = {done, sel_init, round[3:0], const[7:0]}
  logic [13:0] exp_q[$];
  logic [7:0]  const_tab[12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

  permutation_ctrl #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(8)) dut (
    .clock_i        (clock_i),
    .resetb_i       (resetb_i),
    .start_i        (start_i),
    .mode_i         (mode_i),
    .abort_i        (abort_i),
    .ready_o        (ready_o),
    .busy_o         (busy_o),
    .round_o        (round_o),
    .const_o        (const_o),
    .sel_init_o     (sel_init_o),
    .en_reg_state_o (en_reg_state_o),
    .done_o         (done_o),
    .dbg_state_o    (dbg_state_o)
  );

  // Clock / reset
  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Push the enable events for rounds first..last, optionally followed by done.
  task automatic push_rounds(input int first, input int last, input bit with_done);
    for (int r = first; r <= last; r++)
      exp_q.push_back({1'b0, (r == first), 4'(r), const_tab[r]});
    if (with_done) exp_q.push_back({1'b1, 1'b0, 4'd11, 8'h4B});
  endtask

  // Issue one start and measure start-to-done latency.
  task automatic run_op(input bit mode, input int n, input string name);
    int cycles;
    push_rounds(12 - n, 11, 1'b1);
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = mode;
    @(posedge clock_i);
    #1 start_i = 1'b0;
    cycles = 0;
    do begin
      @(negedge clock_i);
      cycles++;
    end while (!done_o && cycles < 40);
    check({name, "_done_latency"}, cycles, n + 1);
    @(negedge clock_i);
    check({name, "_ready_return"}, {31'd0, ready_o}, 32'd1);
  endtask

  // Monitor / scoreboard
  always @(negedge clock_i) begin
    logic [13:0] got;
    logic [13:0] exp;
    if (resetb_i) begin
      if (en_reg_state_o || done_o) begin
        got = {done_o, sel_init_o, round_o, const_o};
        vec_count++;
        if (exp_q.size() == 0) begin
          err_count++;
          $display("FAIL unexpected_event: got %0h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            err_count++;
            $display("FAIL event: got %0h expected %0h", got, exp);
          end
        end
      end
      vec_count++;
      if ((32'(ready_o) + 32'(busy_o) + 32'(done_o)) > 1 || (sel_init_o && !en_reg_state_o)) begin
        err_count++;
        $display("FAIL invariant: rdy=%b busy=%b done=%b sel=%b en=%b required one-hot, sel->en",
                 ready_o, busy_o, done_o, sel_init_o, en_reg_state_o);
      end
    end
  end

  initial begin
    int cyc;
    int done_seen;
    int last_done;
    resetb_i = 1'b0;
    start_i  = 1'b0;
    mode_i   = 1'b0;
    abort_i  = 1'b0;
    #23;
    check("reset_outputs", {ready_o, busy_o, done_o, sel_init_o, en_reg_state_o, round_o, const_o},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'hF0});
    @(negedge clock_i);
    resetb_i = 1'b1;

    // Idle stability
    for (int i = 0; i < 10; i++) begin
      @(negedge clock_i);
      check("idle_stable", {ready_o, busy_o, done_o, en_reg_state_o, round_o, const_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'hF0});
    end

    // Abort beats start in IDLE
    start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clock_i);
    #1 start_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clock_i);
    check("abort_beats_start", {ready_o, busy_o}, {1'b1, 1'b0});

    run_op(1'b0, 12, "pa");
    run_op(1'b1, 8, "pb");

    // Back-to-back p^b with start held high
    push_rounds(4, 11, 1'b1);
    push_rounds(4, 11, 1'b1);
    push_rounds(4, 11, 1'b1);
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = 1'b1;
    @(posedge clock_i);
    cyc = 0;
    done_seen = 0;
    last_done = 0;
    while (done_seen < 3 && cyc < 60) begin
      @(negedge clock_i);
      cyc++;
      if (done_o) begin
        done_seen++;
        if (done_seen == 1) check("b2b_first_done", cyc, 9);
        else                check("b2b_spacing", cyc - last_done, 10);
        last_done = cyc;
        if (done_seen == 3) start_i = 1'b0;
      end
    end
    check("b2b_done_count", done_seen, 3);
    @(negedge clock_i);
    check("b2b_idle_after", {ready_o, busy_o}, {1'b1, 1'b0});

    // Abort at round 6 of p^a, with start/mode toggling mid-run
    push_rounds(0, 6, 1'b0);
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = 1'b0;
    @(posedge clock_i);
    #1 start_i = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clock_i);
      if (i >= 2 && i <= 4) begin
        start_i = ~start_i;
        mode_i  = ~mode_i;
      end else begin
        start_i = 1'b0;
      end
    end
    abort_i = 1'b1;
    mode_i  = 1'b0;
    @(posedge clock_i);
    #1 abort_i = 1'b0;
    @(negedge clock_i);
    check("abort_to_idle", {ready_o, busy_o, en_reg_state_o, done_o}, {1'b1, 1'b0, 1'b0, 1'b0});
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_i);
      if (done_o) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    // Asynchronous reset mid p^b at round 7
    push_rounds(4, 7, 1'b0);
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = 1'b1;
    @(posedge clock_i);
    #1 start_i = 1'b0;
    repeat (4) @(negedge clock_i);
    #2 resetb_i = 1'b0;
    #1;
    check("async_reset_outputs",
          {ready_o, busy_o, done_o, sel_init_o, en_reg_state_o, round_o, const_o},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'hF0});
    @(negedge clock_i);
    resetb_i = 1'b1;
    check("queue_drained_at_reset", exp_q.size(), 0);
    run_op(1'b0, 12, "pa_after_reset");

    repeat (5) @(negedge clock_i);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
